// File: rtl/aline_config_bank.sv
`default_nettype none
// ============================================================================
// Module      : aline_config_bank
// Description : UART-fed packet parser that loads a per-A-line bank of
//               transmit configurations (channel select, pulse shape and
//               per-channel delays) and reads one entry onto the outputs.
// Ports       : clk, rst (async, active-high)
//               uart_data/new_data/wr_en  - byte input path
//               rd_en/which_aline         - bank read request
//               intaking_configs, current_state, err_count - parser status
//               channel_select, pulse_shape, ch_delays, aline_valid,
//               updating_delays           - registered read outputs
// Revision    : 1.0 - initial release
// ============================================================================
module aline_config_bank #(
  parameter int         NUM_CH      = 8,
  parameter int         NUM_ALINES  = 16,
  parameter int         TIMEOUT_CYC = 100000,
  parameter logic [7:0] HDR         = 8'hA5,
  localparam int        AW          = $clog2(NUM_ALINES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           uart_data,
  input  logic                 new_data,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic [AW-1:0]        which_aline,
  output logic                 intaking_configs,
  output logic                 updating_delays,
  output logic [3:0]           current_state,
  output logic [7:0]           channel_select,
  output logic [31:0]          pulse_shape,
  output logic [NUM_CH*16-1:0] ch_delays,
  output logic                 aline_valid,
  output logic [7:0]           err_count
);

  localparam int DW   = NUM_CH * 16;
  localparam int NDLY = 2 * NUM_CH;
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_GET_ALINE = 4'd1,
    S_GET_CHSEL = 4'd2,
    S_GET_PULSE = 4'd3,
    S_GET_DELAY = 4'd4,
    S_GET_CSUM  = 4'd5,
    S_COMMIT    = 4'd6,
    S_DROP      = 4'd7
  } state_t;

  state_t                r_state;
  logic                  r_new_q;
  logic [5:0]            r_cnt;
  logic [TW-1:0]         r_to;
  logic [7:0]            r_csum;
  logic [7:0]            r_sh_aline;
  logic [7:0]            r_sh_chsel;
  logic [31:0]           r_sh_pulse;
  logic [DW-1:0]         r_sh_dly;
  logic [NUM_ALINES-1:0] r_valid;
  logic [7:0]            r_err;

  logic [7:0]            bank_chsel [NUM_ALINES];
  logic [31:0]           bank_pulse [NUM_ALINES];
  logic [DW-1:0]         bank_dly   [NUM_ALINES];

  logic                  w_byte;
  logic                  w_in_get;
  logic                  w_to_hit;
  logic                  w_fwd;
  logic                  w_rd_ok;
  logic [7:0]            w_rd_chsel;
  logic [31:0]           w_rd_pulse;
  logic [DW-1:0]         w_rd_dly;
  logic                  w_rd_valid;

  // One byte per rising edge of new_data, and only while writes are enabled.
  assign w_byte   = new_data & ~r_new_q & wr_en;
  assign w_in_get = (r_state inside {S_GET_ALINE, S_GET_CHSEL, S_GET_PULSE,
                                     S_GET_DELAY, S_GET_CSUM});
  assign w_to_hit = (r_to == TW'(TIMEOUT_CYC - 1));

  // --------------------------------------------------------------------------
  // Packet parser
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_new_q    <= 1'b0;
      r_cnt      <= '0;
      r_to       <= '0;
      r_csum     <= '0;
      r_sh_aline <= '0;
      r_sh_chsel <= '0;
      r_sh_pulse <= '0;
      r_sh_dly   <= '0;
      r_valid    <= '0;
      r_err      <= '0;
    end else begin
      r_new_q <= new_data;

      // Idle-gap watchdog shared by all GET states. A state arm below that
      // accepts a byte overrides the DROP transition (it cannot coincide).
      if (w_in_get) begin
        if (w_byte) begin
          r_to   <= '0;
          r_csum <= r_csum ^ uart_data;
        end else if (w_to_hit) begin
          r_state <= S_DROP;
        end else begin
          r_to <= r_to + 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          r_to  <= '0;
          if (w_byte && (uart_data == HDR)) begin
            r_csum  <= '0;
            r_state <= S_GET_ALINE;
          end
        end
        S_GET_ALINE: if (w_byte) begin
          r_sh_aline <= uart_data;
          r_state    <= S_GET_CHSEL;
        end
        S_GET_CHSEL: if (w_byte) begin
          r_sh_chsel <= uart_data;
          r_cnt      <= '0;
          r_state    <= S_GET_PULSE;
        end
        S_GET_PULSE: if (w_byte) begin
          r_sh_pulse <= {r_sh_pulse[23:0], uart_data};
          if (r_cnt == 6'd3) begin
            r_cnt   <= '0;
            r_state <= S_GET_DELAY;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        S_GET_DELAY: if (w_byte) begin
          // Even byte count = MSB of channel cnt/2, odd = LSB.
          for (int k = 0; k < NUM_CH; k++) begin
            if (r_cnt[5:1] == 5'(k)) begin
              if (r_cnt[0]) r_sh_dly[16*k +: 8]     <= uart_data;
              else          r_sh_dly[16*k + 8 +: 8] <= uart_data;
            end
          end
          if (r_cnt == 6'(NDLY - 1)) begin
            r_cnt   <= '0;
            r_state <= S_GET_CSUM;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        S_GET_CSUM: if (w_byte) begin
          if ((uart_data == r_csum) && (r_sh_aline < 8'(NUM_ALINES)))
            r_state <= S_COMMIT;
          else
            r_state <= S_DROP;
        end
        S_COMMIT: begin
          r_valid[r_sh_aline[AW-1:0]] <= 1'b1;
          r_state <= S_IDLE;
        end
        S_DROP: begin
          if (r_err != 8'hFF) r_err <= r_err + 8'd1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Bank storage is deliberately not reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (r_state == S_COMMIT) begin
      bank_chsel[r_sh_aline[AW-1:0]] <= r_sh_chsel;
      bank_pulse[r_sh_aline[AW-1:0]] <= r_sh_pulse;
      bank_dly[r_sh_aline[AW-1:0]]   <= r_sh_dly;
    end
  end

  // --------------------------------------------------------------------------
  // Read path: a read of the entry being committed this cycle sees the
  // shadow registers (write-first).
  // --------------------------------------------------------------------------
  assign w_fwd   = (r_state == S_COMMIT) && (r_sh_aline == 8'(which_aline));
  assign w_rd_ok = (32'(which_aline) < 32'(NUM_ALINES));

  always_comb begin
    w_rd_chsel = '0;
    w_rd_pulse = '0;
    w_rd_dly   = '0;
    w_rd_valid = 1'b0;
    if (w_fwd) begin
      w_rd_chsel = r_sh_chsel;
      w_rd_pulse = r_sh_pulse;
      w_rd_dly   = r_sh_dly;
      w_rd_valid = 1'b1;
    end else if (w_rd_ok) begin
      w_rd_chsel = bank_chsel[which_aline];
      w_rd_pulse = bank_pulse[which_aline];
      w_rd_dly   = bank_dly[which_aline];
      w_rd_valid = r_valid[which_aline];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      updating_delays <= 1'b0;
      channel_select  <= '0;
      pulse_shape     <= '0;
      ch_delays       <= '0;
      aline_valid     <= 1'b0;
    end else begin
      updating_delays <= rd_en;
      if (rd_en) begin
        channel_select <= w_rd_chsel;
        pulse_shape    <= w_rd_pulse;
        ch_delays      <= w_rd_dly;
        aline_valid    <= w_rd_valid;
      end
    end
  end

  assign intaking_configs = (r_state != S_IDLE);
  assign current_state    = r_state;
  assign err_count        = r_err;

endmodule
`default_nettype wire

// File: doc/aline_config_bank.md
ALINE_CONFIG_BANK -- requirements
Module: aline_config_bank

Interface
REQ-001 Parameter NUM_CH, default 8: number of transmit channels, 1..16.
REQ-002 Parameter NUM_ALINES, default 16: depth of the per-A-line config bank, 2..32; AW = clog2(NUM_ALINES).
REQ-003 Parameter TIMEOUT_CYC, default 100000: idle clk cycles allowed between bytes inside a packet.
REQ-004 Parameter HDR, default 8'hA5: packet start byte.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 uart_data  in  8  received UART byte, valid on the new_data rising edge.
REQ-008 new_data  in  1  byte strobe; each 0->1 transition, detected in the clk domain, delivers one byte.
REQ-009 wr_en  in  1  when low, all incoming bytes are ignored.
REQ-010 rd_en  in  1  one-cycle request to load bank entry which_aline onto the outputs.
REQ-011 which_aline  in  AW  bank entry to read.
REQ-012 intaking_configs  out  1  high whenever the parser is not in IDLE.
REQ-013 updating_delays  out  1  one-cycle pulse when the outputs change on a read.
REQ-014 current_state  out  4  parser state encoding.
REQ-015 channel_select  out  8; pulse_shape  out  32; ch_delays  out  NUM_CH*16, channel k at bits [16k+15:16k].
REQ-016 aline_valid  out  1  the last read entry has been written since reset.
REQ-017 err_count  out  8  saturating count of rejected packets.

Function
REQ-018 Packet: HDR, aline index, channel_select, pulse_shape (4 bytes, MSB first), NUM_CH delays (2 bytes each, MSB first, channel 0 first), checksum; total 8+2*NUM_CH bytes.
REQ-019 Checksum = XOR of every byte after HDR, excluding the checksum byte itself.
REQ-020 States: IDLE=0, GET_ALINE=1, GET_CHSEL=2, GET_PULSE=3, GET_DELAY=4, GET_CSUM=5, COMMIT=6, DROP=7.
REQ-021 IDLE: bytes other than HDR are discarded; HDR -> GET_ALINE.
REQ-022 Each GET state consumes its byte count, using a byte counter, into a shadow register, then advances; GET_CSUM -> COMMIT on match, else DROP.
REQ-023 GET_CSUM -> DROP also when the aline index is >= NUM_ALINES.
REQ-024 COMMIT, one cycle: write the shadow to bank[aline], set valid[aline], return to IDLE.
REQ-025 DROP, one cycle: increment err_count, saturating at 255; no bank write; return to IDLE.
REQ-026 Timeout: outside IDLE, TIMEOUT_CYC cycles with no accepted byte -> DROP.
REQ-027 wr_en low mid-packet: bytes are ignored and the timeout keeps counting.
REQ-028 An HDR byte mid-packet is treated as data, not as a restart.
REQ-029 Read: rd_en sampled at cycle N -> outputs and aline_valid updated at N+1, updating_delays high for cycle N+1 only.
REQ-030 Outputs hold their values between reads, even when their bank entry is rewritten.
REQ-031 rd_en in the same cycle as a COMMIT to the same entry returns the newly committed data (write-first).
REQ-032 rd_en while the parser is busy is serviced normally; reads and writes are independent.
REQ-033 Back-to-back rd_en every cycle is serviced every cycle.

Reset
REQ-034 rst forces state to IDLE and clears the byte counter, timeout counter, new_data edge detector, all valid bits and err_count.
REQ-035 rst forces every output to 0; bank contents need not be cleared.
REQ-036 rst asserted mid-packet discards the packet; err_count is not incremented.

Verification
REQ-037 Valid packet: aline 3, chsel 8'hDF, pulse 32'h0F0F00FF, delay k = 16'h0100+k, correct checksum; then rd_en with which_aline=3 -> next cycle channel_select=DF, pulse_shape=0F0F00FF, ch3 delay=0103, aline_valid=1, updating_delays pulses once.
REQ-038 Same packet with checksum XOR 8'h01 -> DROP, err_count=1, a read of aline 3 returns aline_valid=0.
REQ-039 Packet stalled after 5 bytes for TIMEOUT_CYC cycles -> intaking_configs falls, err_count increments; a following valid packet is accepted.
REQ-040 Aline index = NUM_ALINES -> full packet consumed, then DROP with no bank change.
REQ-041 rd_en for aline 2 coincident with COMMIT of aline 2 -> new data appears at N+1.
REQ-042 rst pulsed during GET_DELAY -> state 0, all outputs 0, err_count 0; a following valid packet loads correctly.
